// File: rtl/record_link_pkg.sv
// Shared defaults and helpers for the record/word link FIFOs (both directions).
package record_link_pkg;

  localparam int unsigned DEF_WORD_SIZE    = 8;
  localparam int unsigned DEF_RECORD_WORDS = 16;
  localparam int unsigned DEF_SLOTS        = 8;

  // Index bits plus one wrap bit that separates full from empty.
  function automatic int unsigned ptr_width(input int unsigned storage_size);
    return $clog2(storage_size) + 1;
  endfunction

endpackage

// File: rtl/record_store.sv
// Word array for record_serializer: record-wide write port, word-wide async read port.
module record_store
  import record_link_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
  parameter int unsigned RECORD_WORDS = DEF_RECORD_WORDS,
  parameter int unsigned SLOTS        = DEF_SLOTS
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [$clog2(SLOTS)-1:0]              wr_rec,
  input  logic [RECORD_WORDS*WORD_SIZE-1:0]     wr_data,
  input  logic [$clog2(SLOTS*RECORD_WORDS)-1:0] rd_idx,
  output logic [WORD_SIZE-1:0]                  rd_data
);

  localparam int unsigned DEPTH = SLOTS * RECORD_WORDS;
  localparam int unsigned OFF_W = $clog2(RECORD_WORDS);

  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < RECORD_WORDS; i++) begin
        mem_q[{wr_rec, OFF_W'(i)}] <= wr_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    rd_data = mem_q[rd_idx];
  end

endmodule

// File: rtl/record_serializer.sv
// Record-in, word-out FWFT FIFO for the host link transmit path.
// Optional sop/eop framing outputs: define RECORD_SERIALIZER_FRAMING_EN.
module record_serializer
  import record_link_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
  parameter int unsigned RECORD_WORDS = DEF_RECORD_WORDS,
  parameter int unsigned SLOTS        = DEF_SLOTS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              write_en,
  input  logic [RECORD_WORDS*WORD_SIZE-1:0] data_in,
  output logic                              full,
  input  logic                              read_en,
  output logic                              empty,
  output logic [WORD_SIZE-1:0]              data_out
`ifdef RECORD_SERIALIZER_FRAMING_EN
  ,
  output logic                              sop,
  output logic                              eop
`endif
);

  localparam int unsigned STORAGE_SIZE = SLOTS * RECORD_WORDS;
  localparam int unsigned PTR_W        = ptr_width(STORAGE_SIZE);
  localparam int unsigned IDX_W        = PTR_W - 1;
  localparam int unsigned OFF_W        = $clog2(RECORD_WORDS);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level;
  logic             do_write, do_read;

  // Flags depend only on registered pointers, never on the enables.
  always_comb begin
    level = wr_ptr_q - rd_ptr_q;
    full  = level > PTR_W'(STORAGE_SIZE - RECORD_WORDS);
    empty = level == '0;
  end

  always_comb begin
    do_write = write_en && !full;
    do_read  = read_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(RECORD_WORDS);
    if (do_read)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  record_store #(
    .WORD_SIZE    (WORD_SIZE),
    .RECORD_WORDS (RECORD_WORDS),
    .SLOTS        (SLOTS)
  ) u_store (
    .clk     (clk),
    .we      (do_write),
    .wr_rec  (wr_ptr_q[IDX_W-1:OFF_W]),
    .wr_data (data_in),
    .rd_idx  (rd_ptr_q[IDX_W-1:0]),
    .rd_data (data_out)
  );

`ifdef RECORD_SERIALIZER_FRAMING_EN
  always_comb begin
    sop = !empty && (rd_ptr_q[OFF_W-1:0] == '0);
    eop = !empty && (rd_ptr_q[OFF_W-1:0] == '1);
  end
`endif

endmodule

// File: tb/tb_record_serializer.sv
// Scoreboard bench for record_serializer (WORD_SIZE=8, RECORD_WORDS=4, SLOTS=2).
module tb_record_serializer;

  localparam int unsigned WS  = 8;
  localparam int unsigned RW  = 4;
  localparam int unsigned SL  = 2;
  localparam int unsigned CAP = SL * RW;

  typedef struct {
    logic [WS-1:0] data;
    logic          sop;
    logic          eop;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            write_en = 1'b0;
  logic [RW*WS-1:0] data_in = '0;
  logic            read_en = 1'b0;
  logic            full, empty;
  logic [WS-1:0]   data_out;
`ifdef RECORD_SERIALIZER_FRAMING_EN
  logic            sop, eop;
`endif

  int total = 0;
  int bad   = 0;
  int mlvl  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  record_serializer #(
    .WORD_SIZE    (WS),
    .RECORD_WORDS (RW),
    .SLOTS        (SL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write_en (write_en),
    .data_in  (data_in),
    .full     (full),
    .read_en  (read_en),
    .empty    (empty),
    .data_out (data_out)
`ifdef RECORD_SERIALIZER_FRAMING_EN
    ,
    .sop      (sop),
    .eop      (eop)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check pre-edge flags against the level model,
  // push accepted words, then advance past the edge.
  task automatic step(input logic we, input logic [31:0] d, input logic re);
    logic do_w, do_r;
    write_en = we;
    data_in  = d;
    read_en  = re;
    chk("empty", {31'd0, empty}, {31'd0, mlvl == 0});
    chk("full",  {31'd0, full},  {31'd0, mlvl > int'(CAP - RW)});
    do_w = we && !(mlvl > int'(CAP - RW));
    do_r = re && (mlvl != 0);
    if (do_w) begin
      for (int i = 0; i < int'(RW); i++) begin
        exp_t e;
        e.data = d[i*WS +: WS];
        e.sop  = (i == 0);
        e.eop  = (i == int'(RW) - 1);
        sb.push_back(e);
      end
    end
    mlvl = mlvl + (do_w ? int'(RW) : 0) - (do_r ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  // Monitor: every word the DUT hands over on a read is compared with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && read_en && !empty) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", {24'd0, data_out}, {24'd0, e.data});
`ifdef RECORD_SERIALIZER_FRAMING_EN
          chk("sop", {31'd0, sop}, {31'd0, e.sop});
          chk("eop", {31'd0, eop}, {31'd0, e.eop});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle after reset, reads on empty ignored.
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full",  {31'd0, full},  32'd0);
`ifdef RECORD_SERIALIZER_FRAMING_EN
    chk("reset_sop", {31'd0, sop}, 32'd0);
    chk("reset_eop", {31'd0, eop}, 32'd0);
`endif
    drain(3);

    // Single record, word 0 first.
    step(1'b1, 32'h4433_2211, 1'b0);
    drain(4);
    chk("empty_after_drain", {31'd0, empty}, 32'd1);

    // Fill, ignored third write, drain both records.
    step(1'b1, 32'hA3A2_A1A0, 1'b0);
    step(1'b1, 32'hB3B2_B1B0, 1'b0);
    chk("full_two_records", {31'd0, full}, 32'd1);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    drain(8);

    // full holds until the whole head record is read, then a write lands.
    step(1'b1, 32'h1312_1110, 1'b0);
    step(1'b1, 32'h2322_2120, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("full_after_1_read", {31'd0, full}, 32'd1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("full_after_4_reads", {31'd0, full}, 32'd0);
    // Level 4: simultaneous write and read -> level 7.
    step(1'b1, 32'h3332_3130, 1'b1);
    chk("full_level7", {31'd0, full}, 32'd1);
    drain(7);
    chk("empty_after_level7", {31'd0, empty}, 32'd1);

    // Asynchronous reset mid-drain.
    step(1'b1, 32'h4342_4140, 1'b0);
    step(1'b1, 32'h5352_5150, 1'b0);
    drain(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_empty", {31'd0, empty}, 32'd1);
    chk("async_rst_full",  {31'd0, full},  32'd0);
    sb.delete();
    mlvl = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h6362_6160, 1'b0);
    drain(4);

    // Wrap-around rounds with distinct records, mixing overlap patterns.
    for (int r = 0; r < 20; r++) begin
      logic [31:0] rec;
      rec = {8'(4*r + 3), 8'(4*r + 2), 8'(4*r + 1), 8'(4*r)} ^ 32'h8080_8080;
      if (r % 3 == 0) begin
        step(1'b1, rec, 1'b0);
        step(1'b1, ~rec, 1'b1);
        drain(7);
      end else begin
        step(1'b1, rec, 1'b0);
        drain(4);
      end
    end
    chk("final_empty", {31'd0, empty}, 32'd1);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
